// File: rtl/irq_encoder_16_if.sv
// rtl/irq_encoder_16_if.sv - request/grant bundle between interrupt sources, encoder and consumer
//   Req[15:0]     request lines, bit i is source i            (master -> slave)
//   Mask[15:0]    bit i = 1 blocks pending[i] from being granted (master -> slave)
//   Ack           consumer accepts the presented Code          (master -> slave)
//   Valid         a code is being presented                    (slave -> master)
//   Code[3:0]     index of the presented request               (slave -> master)
//   Pending[15:0] current pending register                     (slave -> master)
interface irq_encoder_16_if;
    logic [15:0] Req;
    logic [15:0] Mask;
    logic        Ack;
    logic        Valid;
    logic [3:0]  Code;
    logic [15:0] Pending;

    modport master (
        output Req,
        output Mask,
        output Ack,
        input  Valid,
        input  Code,
        input  Pending
    );

    modport slave (
        input  Req,
        input  Mask,
        input  Ack,
        output Valid,
        output Code,
        output Pending
    );
endinterface

// File: rtl/irq_encoder_16.sv
// rtl/irq_encoder_16.sv - registered 16-to-4 priority encoder with request latching and valid/ack handshake
//   EDGE   1: capture on 0->1 transition of Req[i]; 0: capture while Req[i] is high
//   Clock  system clock, all state updates on the rising edge
//   Reset  synchronous, active-high
//   bus    irq_encoder_16_if slave: Req/Mask/Ack in, Valid/Code/Pending out (all outputs registered)
module irq_encoder_16 #(
    parameter bit EDGE = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    irq_encoder_16_if.slave   bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] req_prev_q, req_prev_d;
    logic [3:0]  code_q, code_d;

    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] elig;
    logic [3:0]  winner;

    always_comb begin
        set_vec    = EDGE ? (bus.Req & ~req_prev_q) : bus.Req;
        req_prev_d = bus.Req;

        // Ack only counts while a code is presented; it clears exactly that bit.
        clr_vec = 16'h0000;
        if (state_q == PRESENT && bus.Ack) begin
            clr_vec = 16'h0001 << code_q;
        end

        // OR-ing set last means a fresh event always survives a same-cycle clear.
        pending_d = (pending_q & ~clr_vec) | set_vec;

        // Scan downward so the lowest eligible index is the final assignment.
        elig   = pending_q & ~bus.Mask;
        winner = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (elig[i]) begin
                winner = i[3:0];
            end
        end

        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (elig != 16'h0000) begin
                    code_d  = winner;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Code is frozen here: masks and higher-priority arrivals wait for Ack.
                if (bus.Ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            pending_q  <= 16'h0000;
            req_prev_q <= 16'h0000;
            code_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            req_prev_q <= req_prev_d;
            code_q     <= code_d;
        end
    end

    assign bus.Valid   = (state_q == PRESENT);
    assign bus.Code    = code_q;
    assign bus.Pending = pending_q;

endmodule

// File: tb/tb_irq_encoder_16.sv
// tb/tb_irq_encoder_16.sv - directed table-driven bench for irq_encoder_16 in edge and level modes
module tb_irq_encoder_16;

    logic clk;
    logic rst0;
    logic rst1;

    irq_encoder_16_if bus0 ();
    irq_encoder_16_if bus1 ();

    irq_encoder_16 #(.EDGE(1'b1)) u_edge (
        .Clock (clk),
        .Reset (rst0),
        .bus   (bus0.slave)
    );

    irq_encoder_16 #(.EDGE(1'b0)) u_level (
        .Clock (clk),
        .Reset (rst1),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] mask;
        logic        ack;
        logic        ev;
        logic [3:0]  ec;
        logic [15:0] ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [15:0] q, logic [15:0] m, logic a,
                                logic v, logic [3:0] c, logic [15:0] p);
        vec_t t;
        t.rst = r; t.req = q; t.mask = m; t.ack = a;
        t.ev = v;  t.ec = c;  t.ep = p;
        return t;
    endfunction

    task automatic compare(string name, logic v, logic [3:0] c, logic [15:0] p,
                           logic ev, logic [3:0] ec, logic [15:0] ep);
        checks++;
        if (v !== ev) begin
            failures++;
            $display("FAIL %s valid: got %0b expected %0b", name, v, ev);
        end
        checks++;
        if (c !== ec) begin
            failures++;
            $display("FAIL %s code: got %0d expected %0d", name, c, ec);
        end
        checks++;
        if (p !== ep) begin
            failures++;
            $display("FAIL %s pending: got %h expected %h", name, p, ep);
        end
    endtask

    // One clock on the selected DUT: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(int sel, string name, logic r, logic [15:0] q, logic [15:0] m, logic a,
                        logic ev, logic [3:0] ec, logic [15:0] ep);
        if (sel == 0) begin
            rst0 = r; bus0.Req = q; bus0.Mask = m; bus0.Ack = a;
        end else begin
            rst1 = r; bus1.Req = q; bus1.Mask = m; bus1.Ack = a;
        end
        @(posedge clk);
        #1;
        if (sel == 0) compare(name, bus0.Valid, bus0.Code, bus0.Pending, ev, ec, ep);
        else          compare(name, bus1.Valid, bus1.Code, bus1.Pending, ev, ec, ep);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst0 = 1'b1; bus0.Req = '0; bus0.Mask = '0; bus0.Ack = 1'b0;
        rst1 = 1'b1; bus1.Req = '0; bus1.Mask = '0; bus1.Ack = 1'b0;

        // Reset hold, first-cycle edge capture, reset mid-PRESENT, then 8421 ordering.
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0,  16'h0000));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0,  16'h0000));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0,  16'h0000));
        tbl.push_back(mk(0, 16'hFFFF, 0, 0, 0, 0,  16'hFFFF));
        tbl.push_back(mk(0, 16'hFFFF, 0, 0, 1, 0,  16'hFFFF));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0,  16'h0000));
        tbl.push_back(mk(0, 16'h8421, 0, 0, 0, 0,  16'h8421));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0,  16'h8421));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0,  16'h8420));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 5,  16'h8420));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 5,  16'h8400));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 10, 16'h8400));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 10, 16'h8000));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 15, 16'h8000));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 15, 16'h0000));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 15, 16'h0000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(0, $sformatf("tbl%0d", i), tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].ack,
                 tbl[i].ev, tbl[i].ec, tbl[i].ep);
        end

        // Hold stability: Code 9 stays while Req[2] arrives, then 2 is granted.
        step(0, "hold_cap9",  0, 16'h0200, 0, 0, 0, 15, 16'h0200);
        step(0, "hold_pres9", 0, 16'h0000, 0, 0, 1, 9,  16'h0200);
        step(0, "hold_req2",  0, 16'h0004, 0, 0, 1, 9,  16'h0204);
        step(0, "hold_ack9",  0, 16'h0000, 0, 1, 0, 9,  16'h0004);
        step(0, "hold_pres2", 0, 16'h0000, 0, 0, 1, 2,  16'h0004);
        step(0, "hold_ack2",  0, 16'h0000, 0, 1, 0, 2,  16'h0000);

        // Masking: bit 0 blocked, 3 granted, 0 waits until mask clears.
        step(0, "mask_cap",   0, 16'h0009, 16'h0001, 0, 0, 2, 16'h0009);
        step(0, "mask_pres3", 0, 16'h0000, 16'h0001, 0, 1, 3, 16'h0009);
        step(0, "mask_ack3",  0, 16'h0000, 16'h0001, 1, 0, 3, 16'h0001);
        step(0, "mask_hold1", 0, 16'h0000, 16'h0001, 0, 0, 3, 16'h0001);
        step(0, "mask_hold2", 0, 16'h0000, 16'h0001, 0, 0, 3, 16'h0001);
        step(0, "mask_clr",   0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0001);
        step(0, "mask_ack0",  0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000);

        // Set/clear collision on bit 4: the new edge wins over the ack clear.
        step(0, "col_cap",    0, 16'h0010, 0, 0, 0, 0, 16'h0010);
        step(0, "col_pres",   0, 16'h0000, 0, 0, 1, 4, 16'h0010);
        step(0, "col_ackset", 0, 16'h0010, 0, 1, 0, 4, 16'h0010);
        step(0, "col_repres", 0, 16'h0000, 0, 0, 1, 4, 16'h0010);
        step(0, "col_ack",    0, 16'h0000, 0, 1, 0, 4, 16'h0000);

        // Level mode: held Req[7] keeps re-arming until it falls; reset drops Valid.
        step(1, "lvl_rst",    1, 16'h0080, 0, 0, 0, 0, 16'h0000);
        step(1, "lvl_cap",    0, 16'h0080, 0, 0, 0, 0, 16'h0080);
        step(1, "lvl_pres1",  0, 16'h0080, 0, 0, 1, 7, 16'h0080);
        step(1, "lvl_ack1",   0, 16'h0080, 0, 1, 0, 7, 16'h0080);
        step(1, "lvl_pres2",  0, 16'h0080, 0, 0, 1, 7, 16'h0080);
        step(1, "lvl_ack2",   0, 16'h0080, 0, 1, 0, 7, 16'h0080);
        step(1, "lvl_fall",   0, 16'h0000, 0, 0, 1, 7, 16'h0080);
        step(1, "lvl_ack3",   0, 16'h0000, 0, 1, 0, 7, 16'h0000);
        step(1, "lvl_quiet",  0, 16'h0000, 0, 0, 0, 7, 16'h0000);
        step(1, "lvl_recap",  0, 16'h0080, 0, 0, 0, 7, 16'h0080);
        step(1, "lvl_pres3",  0, 16'h0080, 0, 0, 1, 7, 16'h0080);
        step(1, "lvl_reset",  1, 16'h0080, 0, 0, 0, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
